mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous up/down counter, the general-purpose successor to the fixed 4-bit up counter. It adds configurable width, modulus, count direction, enable, synchronous load, an internal clock-enable prescaler, and terminal-count and wrap flags. It is used wherever the design needs a timebase, a BCD/modulo digit, or an event counter. Cascading is done through `tc` and `wrap`.

## Interface
- `WIDTH`, 4, counter width in bits (≥1)
- `MAX`, 2**WIDTH-1, terminal value; count range is 0..MAX (MAX ≤ 2**WIDTH-1)
- `DIV`, 1, prescaler ratio; the counter advances once every DIV enabled cycles (≥1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  count enable; gates both the prescaler and the counter
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value written on `load`
- `count`  out  WIDTH  current count (registered)
- `tc`  out  1  terminal count, combinational level: `count==MAX` when `up`=1, `count==0` when `up`=0
- `wrap`  out  1  registered one-cycle pulse; high during the cycle in which `count` shows the post-wrap value

## Operation
- Priority at each rising edge is `rst` > `load` > count step.
- **Reset:**
  - `count`=0, `wrap`=0, prescaler=0.
  - `tc` follows from `count`=0: 1 if `up`=0, 0 if `up`=1.
- **Load:**
  - `count` ← min(`load_val`, MAX); `wrap`←0; prescaler←0.
  - Load is independent of `en`.
- **Tick:** `tick` = `en` && (prescaler==DIV-1). When DIV=1, `tick` = `en`.
- **Prescaler:**
  - Counts 0..DIV-1 while `en`=1 and wraps to 0.
  - Holds its value while `en`=0.
- **Step on tick, up=1:**
  - If `count`==MAX, the counter wraps: `count`←0 and `wrap`←1.
  - Otherwise `count`←`count`+1 and `wrap`←0.
- **Step on tick, up=0:**
  - If `count`==0, the counter wraps: `count`←MAX and `wrap`←1.
  - Otherwise `count`←`count`-1 and `wrap`←0.
- **No tick:** `count` holds; `wrap`←0.
- **Arithmetic:** unsigned, WIDTH bits. The next value is computed and compared at WIDTH bits; no carry escapes.
- **Direction change:** `up` may change on any cycle. It takes effect on the next tick, and `tc` re-evaluates immediately.
- **Simultaneous `load` and tick:** load wins. No step and no `wrap` occur that cycle.
- **Reset mid-operation:** reset wins over everything. Any pending prescaler phase is discarded.

## Timing
- `count` latency is 1 cycle from a qualifying edge; `load` → `count` is visible the next cycle.
- `wrap` is coincident with the first cycle of the wrapped `count` value and lasts exactly one cycle.
- With `en` held high, `count` changes every DIV cycles. The first step occurs DIV edges after reset/load release.
- `tc` is combinational from `count` and `up` with no register stage. Downstream cascades use `tc && tick_of_this_stage`, or `wrap` when registered timing is preferred.

## Configuration
- Macro: `MOD_UPDOWN_COUNTER_SATURATE_EN`.
- **Defined:** at the terminal value a tick holds `count` (MAX going up, 0 going down). `wrap` is never asserted. `tc` behaves as normal.
- **Undefined (default):** modulo wrap as specified above.

## Structure
- **Shared package `counter_pkg`:**
  - Direction constants `DIR_UP`=1'b1, `DIR_DOWN`=1'b0.
  - Function `clog2` for sizing the prescaler.
- **Sub-module `counter_prescaler`:**
  - Parameter DIV; ports `clk`, `rst`, `en`, `clr`, `tick`.
  - `clr` is driven by `load`.
  - For DIV=1 it reduces to `tick`=`en` with no state.
- The top level holds the count register, next-state mux, `tc` compare and `wrap` register.

## Test plan
All scenarios use WIDTH=4 and MAX=9 unless noted.
- **Reset and up-count:** `rst` high 2 cycles, then `en`=1, `up`=1, DIV=1 → `count`=0 during reset, then 1,2,…,9,0. `wrap`=1 only in the cycle showing 0. `tc`=1 while `count`=9.
- **Down-count wrap:** `load_val`=2, `load`=1 for 1 cycle, then `up`=0, `en`=1 → 2,1,0,9,8. `wrap` pulses when `count` becomes 9.
- **Load priority and clamp:** `load`=1 with `load_val`=15 while a tick is due → `count`=9 next cycle. No `wrap` and no step that cycle.
- **Prescaler and enable:** DIV=3, `en`=1 → `count` steps every 3 cycles. Drop `en` for 5 cycles mid-phase → `count` and the prescaler phase both hold, and counting resumes at the remaining phase.
- **Mid-count reset:** `rst` asserted for 1 cycle at `count`=6 with DIV=3 → next cycle `count`=0 and `wrap`=0. The first step comes 3 edges after `rst` falls.
- **Saturate build:** with the macro defined, counting up from 7 → 8,9,9,9 with `wrap` never high. Counting down from 1 → 0,0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family: direction encoding
// and a constant-foldable ceil(log2) used to size the prescaler phase register.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Bits needed to hold values 0..value-1; returns at least 1.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int k = 1; k < 31; k++) begin
         if ((1 << k) < value) result = k + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every DIV enabled cycles.
// The phase holds while en is low and restarts from zero on rst or clr.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   generate
      if (DIV <= 1) begin : g_passthru
         // No phase to keep: every enabled cycle is a tick.
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst, clr};
         assign tick     = en;
      end else begin : g_divide
         localparam int PW = clog2(DIV);
         localparam logic [PW-1:0] LAST = PW'(DIV - 1);

         logic [PW-1:0] r_phase;
         logic          w_last;

         assign w_last = (r_phase == LAST);
         assign tick   = en && w_last;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               r_phase <= '0;
            end else if (en) begin
               r_phase <= w_last ? '0 : r_phase + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, enable prescaler, tc and wrap.
// Define MOD_UPDOWN_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH - 1,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             w_tick;
   logic             w_tc;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_step_count;
   logic             w_step_wrap;

   counter_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (w_tick)
   );

   // Terminal value depends on the current direction, so tc tracks up immediately.
   assign w_tc           = (up == DIR_UP) ? (r_count == MAX_V) : (r_count == '0);
   assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

   always_comb begin
      w_step_count = r_count;
      w_step_wrap  = 1'b0;
      if (w_tc) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
         w_step_count = r_count;
         w_step_wrap  = 1'b0;
`else
         w_step_count = (up == DIR_UP) ? '0 : MAX_V;
         w_step_wrap  = 1'b1;
`endif
      end else if (up == DIR_UP) begin
         w_step_count = r_count + 1'b1;
      end else begin
         w_step_count = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_wrap  <= 1'b0;
      end else if (w_tick) begin
         r_count <= w_step_count;
         r_wrap  <= w_step_wrap;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;
   assign tc    = w_tc;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: two instances (DIV=1 and DIV=3, MAX=9)
// share stimulus; a reference model pushes expected count/wrap into a scoreboard queue.
module tb_mod_updown_counter;

   localparam int W  = 4;
   localparam int MX = 9;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count1, count3;
   logic       tc1, tc3, wrap1, wrap3;

   int n_cmp;
   int n_fail;

   typedef struct {
      int         inst;
      logic [3:0] cnt;
      logic       wrp;
   } exp_t;

   exp_t sb[$];

   // Model state per instance: index 0 -> DIV=1, index 1 -> DIV=3.
   int m_cnt   [2];
   int m_phase [2];
   int m_div   [2];
   bit m_valid;

   mod_updown_counter #(.WIDTH(W), .MAX(MX), .DIV(1)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count1), .tc(tc1), .wrap(wrap1)
   );

   mod_updown_counter #(.WIDTH(W), .MAX(MX), .DIV(3)) u_d3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count3), .tc(tc3), .wrap(wrap3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: advance one edge and push expected outputs.
   task automatic model_edge(input int i);
      bit tick;
      bit w;
      w = 1'b0;
      if (rst) begin
         m_cnt[i] = 0;
         m_phase[i] = 0;
      end else if (load) begin
         m_cnt[i] = (int'(load_val) > MX) ? MX : int'(load_val);
         m_phase[i] = 0;
      end else begin
         tick = en && (m_phase[i] == m_div[i] - 1);
         if (en) m_phase[i] = (m_phase[i] + 1) % m_div[i];
         if (tick) begin
            if (up) begin
               if (m_cnt[i] == MX) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
                  m_cnt[i] = MX;
`else
                  m_cnt[i] = 0;
                  w = 1'b1;
`endif
               end else m_cnt[i] = m_cnt[i] + 1;
            end else begin
               if (m_cnt[i] == 0) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
                  m_cnt[i] = 0;
`else
                  m_cnt[i] = MX;
                  w = 1'b1;
`endif
               end else m_cnt[i] = m_cnt[i] - 1;
            end
         end
      end
      sb.push_back('{inst: i, cnt: 4'(m_cnt[i]), wrp: w});
   endtask

   // One transaction: drive inputs, check tc combinationally, clock, check count/wrap.
   task automatic step(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv);
      exp_t x;
      rst = r; en = e; up = u; load = l; load_val = lv;
      #1;
      if (m_valid) begin
         check("tc_div1", tc1, (u ? (m_cnt[0] == MX) : (m_cnt[0] == 0)));
         check("tc_div3", tc3, (u ? (m_cnt[1] == MX) : (m_cnt[1] == 0)));
      end
      model_edge(0);
      model_edge(1);
      if (r) m_valid = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            x = sb.pop_front();
            if (x.inst == 0) begin
               check("count_div1", count1, x.cnt);
               check("wrap_div1",  wrap1,  x.wrp);
            end else begin
               check("count_div3", count3, x.cnt);
               check("wrap_div3",  wrap3,  x.wrp);
            end
         end
      end
      $display("t=%0t rst=%0b en=%0b up=%0b load=%0b lv=%0d | d1 cnt=%0d wrap=%0b | d3 cnt=%0d wrap=%0b",
               $time, r, e, u, l, lv, count1, wrap1, count3, wrap3);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      m_valid = 1'b0;
      m_cnt = '{0, 0};
      m_phase = '{0, 0};
      m_div = '{1, 3};
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      @(posedge clk);
      #1;

      // Reset two cycles, then up-count through the wrap.
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      for (int n = 0; n < 11; n++) step(0, 1, 1, 0, 0);

      // Down-count from 2 through the wrap to 9.
      step(0, 0, 0, 1, 4'd2);
      for (int n = 0; n < 5; n++) step(0, 1, 0, 0, 0);

      // Load with a due tick: clamp to MAX, no step, no wrap.
      step(0, 1, 1, 1, 4'd15);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);

      // Prescaler with enable gap mid-phase.
      step(0, 0, 1, 1, 4'd0);
      for (int n = 0; n < 4; n++) step(0, 1, 1, 0, 0);
      for (int n = 0; n < 5; n++) step(0, 0, 1, 0, 0);
      for (int n = 0; n < 7; n++) step(0, 1, 1, 0, 0);

      // Mid-count reset discards the prescaler phase.
      step(0, 1, 1, 1, 4'd6);
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      for (int n = 0; n < 7; n++) step(0, 1, 1, 0, 0);

      // Terminal behaviour near both ends (saturates when the macro is defined).
      step(0, 0, 1, 1, 4'd7);
      for (int n = 0; n < 4; n++) step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 4'd1);
      for (int n = 0; n < 3; n++) step(0, 1, 0, 0, 0);

      // Direction flip re-evaluates tc immediately at count 0.
      step(0, 0, 1, 1, 4'd0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
